sample_buffer_ctrl: RTL

SAMPLE_BUFFER_CTRL -- requirements
Module: sample_buffer_ctrl

---
 rtl/sample_buffer_ctrl_if.sv | 42 ++++
 rtl/sample_buffer_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sample_buffer_ctrl_if.sv
// rtl/sample_buffer_ctrl_if.sv - capture/readout/RAM signal bundle for sample_buffer_ctrl
// Purpose : groups the capture control, sample input, readout handshake and
//           single-port RAM signals of sample_buffer_ctrl.
// Ports   : slave  - controller side (drives READ_*, RAM_* requests, status)
//           master - host/RAM side (drives ARM, samples, READ_REQ, RAM_DOUT*)
interface sample_buffer_ctrl_if #(
    parameter int ADDR_W = 13
);
    logic              ARM;
    logic [ADDR_W-1:0] POST_COUNT;
    logic              SAMPLE_VALID;
    logic [7:0]        SAMPLE_DATA;
    logic              SAMPLE_TRIG;
    logic              READ_REQ;
    logic              READ_ACK;
    logic [7:0]        READ_DATA;
    logic              READ_TRIG;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic              RAM_EN;
    logic              RAM_WE;
    logic [7:0]        RAM_DIN;
    logic              RAM_DINP;
    logic [7:0]        RAM_DOUT;
    logic              RAM_DOUTP;
    logic              BUSY;
    logic              DONE;
    logic [ADDR_W:0]   SAMPLE_COUNT;

    modport slave (
        input  ARM, POST_COUNT, SAMPLE_VALID, SAMPLE_DATA, SAMPLE_TRIG, READ_REQ,
               RAM_DOUT, RAM_DOUTP,
        output READ_ACK, READ_DATA, READ_TRIG, RAM_ADDR, RAM_EN, RAM_WE, RAM_DIN,
               RAM_DINP, BUSY, DONE, SAMPLE_COUNT
    );

    modport master (
        output ARM, POST_COUNT, SAMPLE_VALID, SAMPLE_DATA, SAMPLE_TRIG, READ_REQ,
               RAM_DOUT, RAM_DOUTP,
        input  READ_ACK, READ_DATA, READ_TRIG, RAM_ADDR, RAM_EN, RAM_WE, RAM_DIN,
               RAM_DINP, BUSY, DONE, SAMPLE_COUNT
    );
endinterface

// File: rtl/sample_buffer_ctrl.sv
// rtl/sample_buffer_ctrl.sv - circular pre/post-trigger sample capture with paced readout
// Purpose : captures 8-bit samples (trigger flag in the RAM parity bit) into an
//           external single-port RAM as a ring buffer, stops POST_COUNT samples
//           after the trigger, then replays oldest-first on READ_REQ.
// Ports   : CLK   - sole clock, rising edge
//           RESET - synchronous, active-high
//           bus   - sample_buffer_ctrl_if.slave (control, samples, readout, RAM, status)
module sample_buffer_ctrl #(
    parameter int ADDR_W = 13
) (
    input  logic                 CLK,
    input  logic                 RESET,
    sample_buffer_ctrl_if.slave  bus
);
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_POST, S_DONE, S_RD_ADDR, S_RD_DATA
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic              wrap_q, wrap_d;
    logic [ADDR_W-1:0] post_len_q, post_len_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic              read_ack_q, read_ack_d;
    logic [7:0]        read_data_q, read_data_d;
    logic              read_trig_q, read_trig_d;

    logic              ram_en, ram_we, ram_dinp, capture_end;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_din;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        remain_d    = remain_q;
        wrap_d      = wrap_q;
        post_len_d  = post_len_q;
        post_cnt_d  = post_cnt_q;
        read_ack_d  = 1'b0;
        read_data_d = read_data_q;
        read_trig_d = read_trig_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_din     = '0;
        ram_dinp    = 1'b0;
        capture_end = 1'b0;

        if (bus.ARM) begin
            // ARM wins over everything in flight; a coincident sample is dropped.
            state_d    = S_ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            wrap_d     = 1'b0;
            post_len_d = bus.POST_COUNT;
        end else begin
            case (state_q)
                S_ARMED, S_POST: begin
                    if (bus.SAMPLE_VALID) begin
                        ram_en   = 1'b1;
                        ram_we   = 1'b1;
                        ram_addr = wr_ptr_q;
                        ram_din  = bus.SAMPLE_DATA;
                        ram_dinp = bus.SAMPLE_TRIG;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (wr_ptr_q == '1) wrap_d = 1'b1;
                        if (count_q != FULL) count_d = count_q + 1'b1;
                        if (state_q == S_ARMED) begin
                            if (bus.SAMPLE_TRIG) begin
                                if (post_len_q == '0) begin
                                    capture_end = 1'b1;
                                end else begin
                                    state_d    = S_POST;
                                    post_cnt_d = post_len_q;
                                end
                            end
                        end else begin
                            post_cnt_d = post_cnt_q - 1'b1;
                            if (post_cnt_q == ADDR_W'(1)) capture_end = 1'b1;
                        end
                        // Next-state pointer/count already include this write,
                        // so the oldest entry is the slot about to be overwritten.
                        if (capture_end) begin
                            state_d  = S_DONE;
                            rd_ptr_d = wrap_d ? wr_ptr_d : '0;
                            remain_d = count_d;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.READ_REQ && (remain_q != '0)) state_d = S_RD_ADDR;
                end
                S_RD_ADDR: begin
                    ram_en   = 1'b1;
                    ram_addr = rd_ptr_q;
                    state_d  = S_RD_DATA;
                end
                S_RD_DATA: begin
                    read_ack_d  = 1'b1;
                    read_data_d = bus.RAM_DOUT;
                    read_trig_d = bus.RAM_DOUTP;
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    remain_d    = remain_q - 1'b1;
                    state_d     = (remain_q == (ADDR_W+1)'(1)) ? S_IDLE : S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remain_q    <= '0;
            wrap_q      <= 1'b0;
            post_len_q  <= '0;
            post_cnt_q  <= '0;
            read_ack_q  <= 1'b0;
            read_data_q <= '0;
            read_trig_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remain_q    <= remain_d;
            wrap_q      <= wrap_d;
            post_len_q  <= post_len_d;
            post_cnt_q  <= post_cnt_d;
            read_ack_q  <= read_ack_d;
            read_data_q <= read_data_d;
            read_trig_q <= read_trig_d;
        end
    end

    // RESET gates the RAM strobes so an abandoned capture cannot land one last write.
    assign bus.RAM_EN       = ram_en & ~RESET;
    assign bus.RAM_WE       = ram_we & ~RESET;
    assign bus.RAM_ADDR     = ram_addr;
    assign bus.RAM_DIN      = ram_din;
    assign bus.RAM_DINP     = ram_dinp;
    assign bus.READ_ACK     = read_ack_q;
    assign bus.READ_DATA    = read_data_q;
    assign bus.READ_TRIG    = read_trig_q;
    assign bus.BUSY         = (state_q == S_ARMED) || (state_q == S_POST);
    assign bus.DONE         = (state_q == S_DONE) || (state_q == S_RD_ADDR) ||
                              (state_q == S_RD_DATA);
    assign bus.SAMPLE_COUNT = count_q;
endmodule
